// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time,
// buffers responses in a 2-entry FIFO feeding IF/ID, handles redirect and HALT.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   imem_req/imem_addr  - fetch request and address (current PC)
//   imem_data/imem_valid- returned instruction and its valid strobe
//   redirect/redirect_pc- flush queue and refetch from target
//   id_ready/id_valid   - IF/ID handshake
//   id_instr/id_pc_inc  - head instruction and its PC+2
//   halted              - fetch stopped after HALT
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc_inc,
    output logic        halted
);

    typedef enum logic {
        FETCH,
        HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        head_q, head_d;
    logic [15:0] instr_q [2];
    logic [15:0] pcinc_q [2];

    logic        accept;
    logic        pop;
    logic        push;
    logic        tail;
    logic [15:0] pc_inc;

    assign pc_inc    = pc_q + 16'd2;
    assign imem_addr = pc_q;
    assign imem_req  = (state_q == FETCH) && (cnt_q != 2'd2)
                       && !redirect && !rst;
    assign accept    = imem_req && imem_valid;
    assign id_valid  = (cnt_q != 2'd0);
    assign pop       = id_valid && id_ready;
    assign push      = accept;
    // With one entry queued the free slot is the other one.
    assign tail      = head_q ^ (cnt_q == 2'd1);
    assign halted    = (state_q == HALTED);
    assign id_instr  = id_valid ? instr_q[head_q] : 16'h0000;
    assign id_pc_inc = id_valid ? pcinc_q[head_q] : 16'h0000;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        if (redirect) begin
            state_d = FETCH;
            pc_d    = redirect_pc;
            cnt_d   = 2'd0;
            head_d  = 1'b0;
        end else begin
            if (accept) begin
                pc_d = pc_inc;
                if (imem_data[15:11] == HALT_OPCODE) begin
                    state_d = HALTED;
                end
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                head_d = ~head_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            head_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
        end
    end

    // Payload storage needs no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && !redirect && push) begin
            instr_q[tail] <= imem_data;
            pcinc_q[tail] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: stream, backpressure, slow memory,
// redirect, HALT and PC wrap, checked with immediate assertions.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc_inc;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc_inc  (id_pc_inc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Memory image: address 10 holds HALT, others 16'h4000 | (addr >> 1).
    always_comb begin
        if (imem_addr == 16'd10) imem_data = 16'h0000;
        else imem_data = 16'h4000 | (imem_addr >> 1);
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic r,
                       input logic rd, input logic [15:0] rpc);
        imem_valid  = v;
        id_ready    = r;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 16'h0);
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        cyc();
        rst = 1'b0;
        drv(0, 0, 0, 16'h0);
        chk("rst_idv", {15'd0, id_valid}, 16'd0);
        chk("rst_hlt", {15'd0, halted}, 16'd0);
        chk("rst_ins", id_instr, 16'h0000);
        chk("rst_inc", id_pc_inc, 16'h0000);
        chk("rst_adr", imem_addr, 16'h0000);

        // Stream
        drv(1, 1, 0, 16'h0);
        chk("s0_req", {15'd0, imem_req}, 16'd1);
        chk("s0_adr", imem_addr, 16'h0000);
        cyc(); drv(1, 1, 0, 16'h0);
        chk("s1_adr", imem_addr, 16'h0002);
        chk("s1_idv", {15'd0, id_valid}, 16'd1);
        chk("s1_ins", id_instr, 16'h4000);
        chk("s1_inc", id_pc_inc, 16'h0002);
        cyc(); drv(1, 1, 0, 16'h0);
        chk("s2_adr", imem_addr, 16'h0004);
        chk("s2_ins", id_instr, 16'h4001);
        chk("s2_inc", id_pc_inc, 16'h0004);
        cyc(); drv(1, 1, 0, 16'h0);
        chk("s3_ins", id_instr, 16'h4002);
        chk("s3_inc", id_pc_inc, 16'h0006);
        rst = 1'b1; #1;
        chk("s3_rstreq", {15'd0, imem_req}, 16'd0);
        cyc();
        rst = 1'b0;

        // Backpressure
        drv(1, 0, 0, 16'h0);
        chk("b0_adr", imem_addr, 16'h0000);
        cyc(); drv(1, 0, 0, 16'h0);
        chk("b1_adr", imem_addr, 16'h0002);
        chk("b1_ins", id_instr, 16'h4000);
        cyc(); drv(1, 0, 0, 16'h0);
        chk("b2_req", {15'd0, imem_req}, 16'd0);
        chk("b2_adr", imem_addr, 16'h0004);
        cyc(); drv(1, 0, 0, 16'h0);
        chk("b3_req", {15'd0, imem_req}, 16'd0);
        chk("b3_ins", id_instr, 16'h4000);
        cyc(); drv(1, 1, 0, 16'h0);
        chk("b4_req", {15'd0, imem_req}, 16'd0);
        chk("b4_ins", id_instr, 16'h4000);
        cyc(); drv(1, 1, 0, 16'h0);
        chk("b5_ins", id_instr, 16'h4001);
        chk("b5_inc", id_pc_inc, 16'h0004);
        chk("b5_req", {15'd0, imem_req}, 16'd1);
        chk("b5_adr", imem_addr, 16'h0004);
        cyc(); drv(0, 1, 0, 16'h0);
        chk("b6_ins", id_instr, 16'h4002);
        chk("b6_inc", id_pc_inc, 16'h0006);

        // Slow memory at pc=6
        chk("m0_req", {15'd0, imem_req}, 16'd1);
        chk("m0_adr", imem_addr, 16'h0006);
        cyc(); drv(0, 1, 0, 16'h0);
        chk("m1_req", {15'd0, imem_req}, 16'd1);
        chk("m1_adr", imem_addr, 16'h0006);
        chk("m1_idv", {15'd0, id_valid}, 16'd0);
        cyc(); drv(0, 1, 0, 16'h0);
        chk("m2_req", {15'd0, imem_req}, 16'd1);
        chk("m2_adr", imem_addr, 16'h0006);
        cyc(); drv(1, 1, 0, 16'h0);
        chk("m3_adr", imem_addr, 16'h0006);
        cyc(); drv(0, 1, 0, 16'h0);
        chk("m4_ins", id_instr, 16'h4003);
        chk("m4_inc", id_pc_inc, 16'h0008);
        chk("m4_adr", imem_addr, 16'h0008);

        // Redirect during wait
        cyc(); drv(1, 1, 1, 16'h0100);
        chk("r0_req", {15'd0, imem_req}, 16'd0);
        cyc(); drv(0, 0, 0, 16'h0);
        chk("r1_idv", {15'd0, id_valid}, 16'd0);
        chk("r1_adr", imem_addr, 16'h0100);
        chk("r1_req", {15'd0, imem_req}, 16'd1);

        // HALT at pc=10
        drv(0, 0, 1, 16'h000A);
        cyc(); drv(1, 0, 0, 16'h0);
        chk("h0_adr", imem_addr, 16'h000A);
        cyc(); drv(1, 0, 0, 16'h0);
        chk("h1_hlt", {15'd0, halted}, 16'd1);
        chk("h1_req", {15'd0, imem_req}, 16'd0);
        chk("h1_ins", id_instr, 16'h0000);
        chk("h1_inc", id_pc_inc, 16'h000C);
        chk("h1_adr", imem_addr, 16'h000C);
        cyc(); drv(1, 1, 0, 16'h0);
        chk("h2_req", {15'd0, imem_req}, 16'd0);
        cyc(); drv(1, 0, 1, 16'h0020);
        chk("h3_idv", {15'd0, id_valid}, 16'd0);
        chk("h3_hlt", {15'd0, halted}, 16'd1);
        cyc(); drv(1, 0, 0, 16'h0);
        chk("h4_hlt", {15'd0, halted}, 16'd0);
        chk("h4_req", {15'd0, imem_req}, 16'd1);
        chk("h4_adr", imem_addr, 16'h0020);
        cyc(); drv(1, 0, 1, 16'hFFFE);
        chk("h5_ins", id_instr, 16'h4010);
        chk("h5_inc", id_pc_inc, 16'h0022);

        // Wrap
        cyc(); drv(1, 1, 0, 16'h0);
        chk("w0_adr", imem_addr, 16'hFFFE);
        chk("w0_idv", {15'd0, id_valid}, 16'd0);
        cyc(); drv(0, 0, 0, 16'h0);
        chk("w1_ins", id_instr, 16'h7FFF);
        chk("w1_inc", id_pc_inc, 16'h0000);
        chk("w1_adr", imem_addr, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
